// File: rtl/clz_operand_stage_if.sv
// Request/response bundle between decode, the operand stage and the CLZ unit.
// The master side drives requests and consumes conditioned operands.
interface clz_operand_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_rs1;
    logic [4:0]  in_rd_idx;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_operand;
    logic        out_zero;
    logic        out_is_ctz;
    logic        out_illegal;
    logic [4:0]  out_rd_idx;
    logic [1:0]  out_count;

    modport master (
        output in_valid, in_op, in_rs1, in_rd_idx, out_ready,
        input  in_ready, out_valid, out_operand, out_zero, out_is_ctz, out_illegal,
               out_rd_idx, out_count
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rd_idx, out_ready,
        output in_ready, out_valid, out_operand, out_zero, out_is_ctz, out_illegal,
               out_rd_idx, out_count
    );
endinterface

// File: rtl/clz_operand_stage.sv
// Operand conditioning ahead of the CLZ unit: bit-reverses CTZ operands, flags zero
// and illegal ops, and buffers requests in a 2-entry FIFO.
module clz_operand_stage #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    clz_operand_stage_if.slave   bus
);

    typedef struct packed {
        logic [31:0] operand;
        logic        zero;
        logic        is_ctz;
        logic        illegal;
        logic [4:0]  rd_idx;
    } entry_t;

    entry_t      mem_q [DEPTH];
    entry_t      mem_d [DEPTH];
    logic        wptr_q, wptr_d;
    logic        rptr_q, rptr_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] rev;
    entry_t      new_entry;
    logic        push, pop;

    // Readiness depends only on registered occupancy, never on out_ready.
    assign bus.in_ready  = (count_q != 2'(DEPTH)) && !rst;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_count = count_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    assign bus.out_operand = mem_q[rptr_q].operand;
    assign bus.out_zero    = mem_q[rptr_q].zero;
    assign bus.out_is_ctz  = mem_q[rptr_q].is_ctz;
    assign bus.out_illegal = mem_q[rptr_q].illegal;
    assign bus.out_rd_idx  = mem_q[rptr_q].rd_idx;

    always_comb begin
        rev = '0;
        for (int i = 0; i < 32; i++) begin
            rev[i] = bus.in_rs1[31-i];
        end
        new_entry.operand = bus.in_rs1;
        new_entry.zero    = (bus.in_rs1 == 32'd0);
        new_entry.is_ctz  = 1'b0;
        new_entry.illegal = 1'b0;
        new_entry.rd_idx  = bus.in_rd_idx;
        unique case (bus.in_op)
            2'b00: ;
            2'b01: begin
                new_entry.operand = rev;
                new_entry.is_ctz  = 1'b1;
            end
            default: new_entry.illegal = 1'b1;
        endcase
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wptr_q] = new_entry;
        end
        wptr_d  = wptr_q ^ push;
        rptr_d  = rptr_q ^ pop;
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: doc/clz_operand_stage.md
# clz_operand_stage

Registered operand-conditioning stage that sits directly upstream of the combinational count-leading-zeros unit in the bit-manipulation execute path. It accepts CLZ/CTZ requests over a valid/ready handshake and bit-reverses the operand for CTZ, so the downstream CLZ computes trailing zeros. It flags all-zero operands, because the CLZ unit leaves that case undefined. Requests are buffered in a 2-entry FIFO so the decode stage is decoupled from writeback back-pressure.

## Interface
- DEPTH, 2, FIFO entries; fixed at 2; any other value is unsupported
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  stage can accept a request this cycle
- in_op  in  2  00 = CLZ, 01 = CTZ, 10/11 = illegal
- in_rs1  in  32  source operand
- in_rd_idx  in  5  destination register index, carried unchanged
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head entry
- out_operand  out  32  conditioned operand fed to CLZ
- out_zero  out  1  original in_rs1 was 0; downstream forces result to 32
- out_is_ctz  out  1  entry was a CTZ request
- out_illegal  out  1  in_op was 10 or 11
- out_rd_idx  out  5  carried destination index
- out_count  out  2  current FIFO occupancy, 0..2

## Operation
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- Conditioning is applied at push time and stored in the entry:
  - CLZ: operand = rs1.
  - CTZ: operand[i] = rs1[31-i] for i = 0..31.
  - Illegal op: operand = rs1 unmodified, illegal = 1, is_ctz = 0.
  - zero = (rs1 == 32'd0) for every op, including illegal.
- Storage is 2 entries with read and write pointers of 1 bit each, wrapping 1 -> 0, and a 2-bit count.
  - Push only: count +1. Pop only: count -1. Push and pop together: count unchanged; both pointers advance.
- in_ready = (count != 2) and rst deasserted.
  - Computed from registered state only; there is no combinational path from out_ready to in_ready.
- out_valid = (count != 0).
- out_* data fields are the head entry and stay stable while out_valid && !out_ready.
- Order is strict FIFO; entries are never dropped or reordered.
- Push while full cannot occur, since in_ready is 0. Pop while empty cannot occur, since out_valid is 0.
- Reset asserted at any time, including mid-transfer: count, pointers and all entries clear immediately. In-flight requests are discarded.

## Timing
- Reset values: in_ready 0 while rst is high and 1 on the first cycle after release; out_valid 0; out_count 0; out_operand, out_zero, out_is_ctz, out_illegal and out_rd_idx all 0.
- Latency: a request pushed at edge N appears on out_* after edge N (1 cycle) when the FIFO was empty.
- Throughput: 1 request/cycle when out_ready is held high.
- When full with out_ready=1: the pop occurs at edge N; in_ready rises only after edge N, so there is 1 bubble cycle on the input side.
- Empty with push and no pop: count 0 -> 1. Count 1 with push and pop: count stays 1, and the new entry is at head after the edge.
- Data fields are not guaranteed to be 0 when out_valid=0, except after reset.

## Test plan
- Reset: hold rst for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_count=0 throughout. After release, in_ready=1 on the next cycle.
- CTZ reverse: op=01, rs1=32'h0000_0010, rd=7 -> next cycle out_operand=32'h0800_0000, out_is_ctz=1, out_zero=0, out_rd_idx=7.
- Zero and illegal:
  - CLZ with rs1=0 -> out_zero=1, out_operand=0.
  - op=11, rs1=32'hDEAD_BEEF -> out_illegal=1, out_operand=32'hDEAD_BEEF.
- Back-pressure: out_ready=0; push A=32'h1 then B=32'h2 -> out_count=2, in_ready=0, third request (C) stalled, head=A stable. Then raise out_ready -> A, B, C delivered in order, with exactly 1 input bubble.
- Simultaneous push/pop at count=1 for 10 cycles with incrementing rs1 -> out_count stays 1, outputs follow inputs with 1 cycle of delay, and pointers wrap correctly.
- Mid-operation reset: FIFO full, assert rst asynchronously between edges -> out_valid and out_count go to 0 immediately. Pre-reset entries never appear after release.
